// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the CPU (master 0) and the debug loader (master 1)
// in front of the single-port datamem; one access in flight, IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_rd,
  output logic              mem_wrt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wrt_q, mem_wrt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic                m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic                sel_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                in_rng_s;
  logic [DATA_W-1:0]   rdata_s;

  // Next-state and next-output decode; every output is registered so it is
  // already valid in the cycle its state is entered.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    err_d        = err_q;
    busy_d       = busy_q;
    mem_rd_d     = 1'b0;
    mem_wrt_d    = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = '0;
    m1_rdata_d   = '0;
    // On a tie the master that did not win last time gets the grant.
    sel_s        = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    sel_we_s     = sel_s ? m1_we    : m0_we;
    sel_addr_s   = sel_s ? m1_addr  : m0_addr;
    sel_wdata_s  = sel_s ? m1_wdata : m0_wdata;
    in_rng_s     = (sel_addr_s < DEPTH_A);
    rdata_s      = (we_q || err_q) ? '0 : mem_rdata;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d        = sel_s;
          we_d         = sel_we_s;
          err_d        = ~in_rng_s;
          last_grant_d = sel_s;
          mem_rd_d     = in_rng_s & ~sel_we_s;
          mem_wrt_d    = in_rng_s & sel_we_s;
          mem_addr_d   = sel_addr_s;
          mem_wdata_d  = sel_wdata_s;
          busy_d       = 1'b1;
          state_d      = ACCESS;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (gnt_q) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = rdata_s;
          m1_err_d   = err_q;
        end else begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = rdata_s;
          m0_err_d   = err_q;
        end
        busy_d  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wrt_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      mem_rd_q     <= mem_rd_d;
      mem_wrt_q    <= mem_wrt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wrt   = mem_wrt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner sequences,
// and random two-master traffic checked against a serial memory model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wrt, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_arr [0:1023] = '{default: 32'd0};

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024)) dut (
    .clk(clk), .reset(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // datamem stand-in: combinational read, write on the clock edge
  assign mem_rdata = (mem_addr < 32'd1024) ? mem_arr[mem_addr[9:0]] : 32'd0;
  always @(posedge clk) begin
    if (mem_wrt && mem_addr < 32'd1024) mem_arr[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit m, input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd;
    end
  endtask

  // One transaction from master m, starting at a negedge while the arbiter is idle.
  task automatic run_txn(input bit m, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         output bit got, output logic [31:0] rd, output bit er,
                         output int lat, output int nwr, output int nrd, output bit oth);
    @(negedge clk);
    drive(m, 1'b1, we, a, wd);
    got = 1'b0; rd = 32'd0; er = 1'b0; lat = 0; nwr = 0; nrd = 0; oth = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_wrt) nwr++;
      if (mem_rd) nrd++;
      if (m ? m0_ack : m1_ack) oth = 1'b1;
      if (m ? m1_ack : m0_ack) begin
        got = 1'b1;
        rd  = m ? m1_rdata : m0_rdata;
        er  = m ? m1_err : m0_err;
      end
    end
    drive(m, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [11];

  initial begin
    bit got, er, oth;
    logic [31:0] rd;
    int lat, nwr, nrd;
    int order [$];
    logic [31:0] ref_mem [0:15];
    bit          p_req [2];
    bit          p_we [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd [2];
    int          p_wait [2];
    int          n_acks;

    vt[0]  = '{1'b0, 1'b1, 32'd5,          32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 32'd5,          32'h0,        1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 1'b1, 32'd1024,       32'h11111111, 1'b1, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 32'd1023,       32'h0,        1'b0, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 32'hFFFFFFFF,   32'h0,        1'b1, 32'h0};
    vt[5]  = '{1'b1, 1'b1, 32'd1023,       32'h0000A5A5, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 1'b0, 32'd1023,       32'h0,        1'b0, 32'h0000A5A5};
    vt[7]  = '{1'b0, 1'b1, 32'd0,          32'h00000001, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 32'd0,          32'h0,        1'b0, 32'h00000001};
    vt[9]  = '{1'b1, 1'b0, 32'd1024,       32'h0,        1'b1, 32'h0};
    vt[10] = '{1'b0, 1'b0, 32'd5,          32'h0,        1'b0, 32'hDEADBEEF};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ctl", {27'd0, mem_rd, mem_wrt, m0_ack, m1_ack, m0_err | m1_err}, 32'd0);
    chk("reset_data", mem_addr | mem_wdata | m0_rdata | m1_rdata, 32'd0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      run_txn(vt[i].m, vt[i].we, vt[i].addr, vt[i].wd, got, rd, er, lat, nwr, nrd, oth);
      chk($sformatf("vec%0d_ack", i), {31'd0, got}, 32'd1);
      chk($sformatf("vec%0d_latency", i), lat, 32'd2);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
      chk($sformatf("vec%0d_wrt_cycles", i), nwr, (vt[i].we && !vt[i].exp_err) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_rd_cycles", i), nrd, (!vt[i].we && !vt[i].exp_err) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_other_ack", i), {31'd0, oth}, 32'd0);
    end

    // Both masters requesting continuously from reset: strict alternation, m0 first
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd5, 32'd0);
    for (int c = 0; c < 40 && order.size() < 8; c++) begin
      @(negedge clk);
      if (m0_ack) begin
        order.push_back(0);
        chk("alt_m0_rdata", m0_rdata, 32'h00000001);
      end
      if (m1_ack) begin
        order.push_back(1);
        chk("alt_m1_rdata", m1_rdata, 32'hDEADBEEF);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("alt_count", order.size(), 32'd8);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("alt_grant%0d", i), order[i], i % 2);
    @(negedge clk);

    // Address change during ACCESS must not affect the latched command
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    chk("latch_mem_addr", mem_addr, 32'd5);
    m0_addr = 32'd0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (m0_ack) begin
        got = 1'b1;
        chk("latch_rdata", m0_rdata, 32'hDEADBEEF);
      end
    end
    chk("latch_ack", {31'd0, got}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Reset during ACCESS of an m1 write aborts it
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'd7, 32'h00001234);
    @(negedge clk);
    chk("abort_wrt_before", {31'd0, mem_wrt}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ctl", {28'd0, mem_rd, mem_wrt, m0_ack, m1_ack}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) got = 1'b1;
    end
    chk("abort_no_ack", {31'd0, got}, 32'd0);
    run_txn(1'b0, 1'b0, 32'd7, 32'd0, got, rd, er, lat, nwr, nrd, oth);
    chk("abort_read_ack", {31'd0, got}, 32'd1);
    chk("abort_read_data", rd, 32'd0);

    // Random two-master traffic against a serial memory model
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
    for (int m = 0; m < 2; m++) begin
      p_req[m] = 1'b0; p_we[m] = 1'b0; p_addr[m] = 32'd0; p_wd[m] = 32'd0; p_wait[m] = 0;
    end
    n_acks = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      chk("rand_rd_wrt_excl", {31'd0, mem_rd & mem_wrt}, 32'd0);
      chk("rand_both_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
      chk("rand_mem_idle", {31'd0, ~busy & (mem_rd | mem_wrt)}, 32'd0);
      for (int m = 0; m < 2; m++) begin
        bit          ack_m, err_m, exp_err;
        logic [31:0] rd_m, exp_rd;
        ack_m = (m == 1) ? m1_ack : m0_ack;
        err_m = (m == 1) ? m1_err : m0_err;
        rd_m  = (m == 1) ? m1_rdata : m0_rdata;
        if (ack_m) begin
          n_acks++;
          chk($sformatf("rand_m%0d_ack_pending", m), {31'd0, p_req[m]}, 32'd1);
          exp_err = (p_addr[m] >= 32'd1024);
          if (exp_err || p_we[m]) exp_rd = 32'd0;
          else exp_rd = ref_mem[p_addr[m] - 32'd200];
          chk($sformatf("rand_m%0d_err a=%h", m, p_addr[m]), {31'd0, err_m}, {31'd0, exp_err});
          chk($sformatf("rand_m%0d_rdata a=%h", m, p_addr[m]), rd_m, exp_rd);
          if (p_we[m] && !exp_err) ref_mem[p_addr[m] - 32'd200] = p_wd[m];
          p_req[m] = 1'b0;
        end else if (p_req[m]) begin
          p_wait[m]++;
          if (p_wait[m] > 8) begin
            chk($sformatf("rand_m%0d_starved", m), p_wait[m], 32'd8);
            p_req[m] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          int r;
          r = $urandom_range(0, 9);
          if (r < 7) p_addr[m] = 32'd200 + $urandom_range(0, 15);
          else if (r < 9) p_addr[m] = 32'd1024 + $urandom_range(0, 3);
          else p_addr[m] = 32'hFFFFFFF0 + $urandom_range(0, 15);
          p_we[m]   = $urandom_range(0, 1) == 1;
          p_wd[m]   = $urandom;
          p_req[m]  = 1'b1;
          p_wait[m] = 0;
        end
        drive(m[0], p_req[m], p_we[m], p_addr[m], p_wd[m]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rand_enough_acks", {31'd0, n_acks > 100}, 32'd1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
